// File: rtl/stack_mem_controller.sv
// MEM-stage initiator for a 16-bit word data memory with a downward-growing stack.
// Optional macro STACK_CHECK_EN adds a sticky stack_err output and suppresses over/underflowing accesses.
module stack_mem_controller #(
    parameter int ADDR_W  = 11,
    parameter int SP_INIT = 2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op,
    input  logic [31:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic [31:0] pc_in,
    input  logic [15:0] mem_read_data,
    output logic [31:0] mem_address,
    output logic [15:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_cs,
    output logic        stall,
    output logic [15:0] load_data,
    output logic        load_valid,
    output logic [31:0] pc_out,
    output logic        pc_valid,
`ifdef STACK_CHECK_EN
    output logic        stack_err,
`endif
    output logic [31:0] sp_out
);
    typedef enum logic {IDLE, SECOND} state_t;

    localparam logic [2:0] OP_LOAD = 3'd1, OP_STORE = 3'd2, OP_PUSH = 3'd3,
                           OP_POP = 3'd4, OP_PUSH_PC = 3'd5, OP_POP_PC = 3'd6;
    localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_INIT);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sp_q, sp_d, sp_inc, sp_dec;
    logic                is_pop_q, is_pop_d, abort_q, abort_d;
    logic [15:0]         pc_lo_q, pc_lo_d, load_data_q, load_data_d;
    logic [31:0]         pc_out_q, pc_out_d, addr_c;
    logic                load_valid_q, load_valid_d, pc_valid_q, pc_valid_d;
    logic                rd_c, wr_c, stall_c, ovf, udf;
    logic [15:0]         wdata_c;

    assign sp_inc = sp_q + ADDR_W'(1);
    assign sp_dec = sp_q - ADDR_W'(1);

`ifdef STACK_CHECK_EN
    assign ovf = (sp_q == '0);
    assign udf = (sp_q == SP_RST);
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        is_pop_d     = is_pop_q;
        abort_d      = abort_q;
        pc_lo_d      = pc_lo_q;
        load_data_d  = load_data_q;
        pc_out_d     = pc_out_q;
        load_valid_d = 1'b0;
        pc_valid_d   = 1'b0;
        rd_c         = 1'b0;
        wr_c         = 1'b0;
        stall_c      = 1'b0;
        addr_c       = '0;
        wdata_c      = '0;
        if (state_q == IDLE) begin
            case (op)
                OP_LOAD: begin
                    rd_c = 1'b1; addr_c = addr_in;
                    load_data_d = mem_read_data; load_valid_d = 1'b1;
                end
                OP_STORE: begin
                    wr_c = 1'b1; addr_c = addr_in; wdata_c = wdata_in;
                end
                OP_PUSH: if (!ovf) begin
                    wr_c = 1'b1; addr_c = 32'(sp_q); wdata_c = wdata_in; sp_d = sp_dec;
                end
                OP_POP: if (!udf) begin
                    rd_c = 1'b1; addr_c = 32'(sp_inc); sp_d = sp_inc;
                    load_data_d = mem_read_data; load_valid_d = 1'b1;
                end
                OP_PUSH_PC: begin
                    stall_c = 1'b1; state_d = SECOND; is_pop_d = 1'b0;
                    pc_lo_d = pc_in[15:0]; abort_d = ovf;
                    if (!ovf) begin
                        wr_c = 1'b1; addr_c = 32'(sp_q); wdata_c = pc_in[31:16]; sp_d = sp_dec;
                    end
                end
                OP_POP_PC: begin
                    stall_c = 1'b1; state_d = SECOND; is_pop_d = 1'b1; abort_d = udf;
                    if (!udf) begin
                        rd_c = 1'b1; addr_c = 32'(sp_inc); sp_d = sp_inc;
                        pc_lo_d = mem_read_data;
                    end
                end
                default: ;
            endcase
        end else begin
            // Second word of a PC save/restore; op is ignored here.
            state_d = IDLE;
            if (!abort_q) begin
                if (is_pop_q) begin
                    if (!udf) begin
                        rd_c = 1'b1; addr_c = 32'(sp_inc); sp_d = sp_inc;
                        pc_out_d = {mem_read_data, pc_lo_q}; pc_valid_d = 1'b1;
                    end
                end else if (!ovf) begin
                    wr_c = 1'b1; addr_c = 32'(sp_q); wdata_c = pc_lo_q; sp_d = sp_dec;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sp_q         <= SP_RST;
            is_pop_q     <= 1'b0;
            abort_q      <= 1'b0;
            pc_lo_q      <= '0;
            load_data_q  <= '0;
            pc_out_q     <= '0;
            load_valid_q <= 1'b0;
            pc_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            is_pop_q     <= is_pop_d;
            abort_q      <= abort_d;
            pc_lo_q      <= pc_lo_d;
            load_data_q  <= load_data_d;
            pc_out_q     <= pc_out_d;
            load_valid_q <= load_valid_d;
            pc_valid_q   <= pc_valid_d;
        end
    end

`ifdef STACK_CHECK_EN
    logic err_q, err_d;
    logic push_word, pop_word;

    // Word-level intent regardless of suppression, so the flag sees blocked accesses.
    assign push_word = (state_q == IDLE) ? (op == OP_PUSH || op == OP_PUSH_PC)
                                         : (!abort_q && !is_pop_q);
    assign pop_word  = (state_q == IDLE) ? (op == OP_POP || op == OP_POP_PC)
                                         : (!abort_q && is_pop_q);

    always_comb begin
        err_d = err_q | (push_word & ovf) | (pop_word & udf);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign stack_err = err_q;
`endif

    assign mem_read       = rd_c & ~rst;
    assign mem_write      = wr_c & ~rst;
    assign mem_cs         = mem_read | mem_write;
    assign stall          = stall_c & ~rst;
    assign mem_address    = addr_c;
    assign mem_write_data = wdata_c;
    assign load_data      = load_data_q;
    assign load_valid     = load_valid_q;
    assign pc_out         = pc_out_q;
    assign pc_valid       = pc_valid_q;
    assign sp_out         = 32'(sp_q);
endmodule

// File: tb/tb_stack_mem_controller.sv
// Directed bench for stack_mem_controller with a behavioural 2K-word memory.
module tb_stack_mem_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] addr_in, pc_in, mem_address, pc_out, sp_out;
    logic [15:0] wdata_in, mem_read_data, mem_write_data, load_data;
    logic        mem_read, mem_write, mem_cs, stall, load_valid, pc_valid;
`ifdef STACK_CHECK_EN
    logic        stack_err;
`endif

    logic [15:0] tbmem [0:2047];
    int ncmp = 0;
    int nerr = 0;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, STORE = 3'd2, PUSH = 3'd3,
                           POP = 3'd4, PUSH_PC = 3'd5, POP_PC = 3'd6, OP7 = 3'd7;

    stack_mem_controller dut (
        .clk(clk), .rst(rst), .op(op), .addr_in(addr_in), .wdata_in(wdata_in),
        .pc_in(pc_in), .mem_read_data(mem_read_data), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_cs(mem_cs), .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .pc_out(pc_out), .pc_valid(pc_valid),
`ifdef STACK_CHECK_EN
        .stack_err(stack_err),
`endif
        .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) tbmem[mem_address[10:0]] <= mem_write_data;
    assign mem_read_data = tbmem[mem_address[10:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [15:0] w,
                         input logic [31:0] p);
        op = o; addr_in = a; wdata_in = w; pc_in = p;
    endtask

    initial begin
        rst = 1'b1;
        drive(PUSH, 32'h0, 16'hDEAD, 32'h0);
        #1;
        chk("rst_wr_forced", {31'b0, mem_write}, 32'd0);
        chk("rst_cs_forced", {31'b0, mem_cs}, 32'd0);
        tick; tick;
        rst = 1'b0;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("rst_sp", sp_out, 32'd2047);
        chk("rst_ld", {16'b0, load_data}, 32'd0);
        chk("rst_lv", {31'b0, load_valid}, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_pv", {31'b0, pc_valid}, 32'd0);
`ifdef STACK_CHECK_EN
        chk("rst_err", {31'b0, stack_err}, 32'd0);
`endif

        // PUSH / PUSH / POP / POP
        drive(PUSH, 32'h0, 16'hAAAA, 32'h0);
        #1;
        chk("push1_wr", {31'b0, mem_write}, 32'd1);
        chk("push1_addr", mem_address, 32'd2047);
        tick;
        drive(PUSH, 32'h0, 16'h5555, 32'h0);
        tick;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("push_mem2047", {16'b0, tbmem[2047]}, 32'hAAAA);
        chk("push_mem2046", {16'b0, tbmem[2046]}, 32'h5555);
        chk("push_sp", sp_out, 32'd2045);
        drive(POP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("pop1_rd", {31'b0, mem_read}, 32'd1);
        chk("pop1_addr", mem_address, 32'd2046);
        tick;
        chk("pop1_lv", {31'b0, load_valid}, 32'd1);
        chk("pop1_ld", {16'b0, load_data}, 32'h5555);
        tick;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("pop2_lv", {31'b0, load_valid}, 32'd1);
        chk("pop2_ld", {16'b0, load_data}, 32'hAAAA);
        chk("pop2_sp", sp_out, 32'd2047);
        tick;
        chk("pop_lv_drop", {31'b0, load_valid}, 32'd0);

        // STORE then LOAD
        drive(STORE, 32'h10, 16'h1234, 32'h0);
        tick;
        drive(LOAD, 32'h10, 16'h0, 32'h0);
        #1;
        chk("load_rd", {31'b0, mem_read}, 32'd1);
        chk("load_wr", {31'b0, mem_write}, 32'd0);
        tick;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("load_lv", {31'b0, load_valid}, 32'd1);
        chk("load_ld", {16'b0, load_data}, 32'h1234);
        chk("load_sp", sp_out, 32'd2047);

        // PUSH_PC then POP_PC
        drive(PUSH_PC, 32'h0, 16'h0, 32'h0001_ABCD);
        #1;
        chk("ppc1_stall", {31'b0, stall}, 32'd1);
        chk("ppc1_addr", mem_address, 32'd2047);
        chk("ppc1_data", {16'b0, mem_write_data}, 32'h0001);
        tick;
        drive(POP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("ppc2_stall", {31'b0, stall}, 32'd0);
        chk("ppc2_rd_ignored", {31'b0, mem_read}, 32'd0);
        chk("ppc2_addr", mem_address, 32'd2046);
        chk("ppc2_data", {16'b0, mem_write_data}, 32'hABCD);
        tick;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("ppc_mem2047", {16'b0, tbmem[2047]}, 32'h0001);
        chk("ppc_mem2046", {16'b0, tbmem[2046]}, 32'hABCD);
        chk("ppc_sp", sp_out, 32'd2045);
        chk("ppc_stall_done", {31'b0, stall}, 32'd0);
        drive(POP_PC, 32'h0, 16'h0, 32'h0);
        #1;
        chk("opc1_stall", {31'b0, stall}, 32'd1);
        chk("opc1_addr", mem_address, 32'd2046);
        tick;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("opc2_addr", mem_address, 32'd2047);
        chk("opc2_pv", {31'b0, pc_valid}, 32'd0);
        tick;
        chk("opc_pv", {31'b0, pc_valid}, 32'd1);
        chk("opc_pc", pc_out, 32'h0001_ABCD);
        chk("opc_sp", sp_out, 32'd2047);
        tick;
        chk("opc_pv_drop", {31'b0, pc_valid}, 32'd0);

        // Reset during the second cycle of PUSH_PC
        drive(PUSH_PC, 32'h0, 16'h0, 32'h2222_3333);
        tick;
        rst = 1'b1;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("rmid_wr", {31'b0, mem_write}, 32'd0);
        chk("rmid_stall", {31'b0, stall}, 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("rmid_wr_after", {31'b0, mem_write}, 32'd0);
        chk("rmid_sp", sp_out, 32'd2047);
        tick;
        chk("rmid_mem2046", {16'b0, tbmem[2046]}, 32'hABCD);
        chk("rmid_mem2047", {16'b0, tbmem[2047]}, 32'h2222);

        // POP from an empty stack
        drive(STORE, 32'h0, 16'h0BEE, 32'h0);
        tick;
        drive(POP, 32'h0, 16'h0, 32'h0);
        #1;
`ifdef STACK_CHECK_EN
        chk("udf_rd", {31'b0, mem_read}, 32'd0);
        chk("udf_cs", {31'b0, mem_cs}, 32'd0);
        tick;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("udf_err", {31'b0, stack_err}, 32'd1);
        chk("udf_lv", {31'b0, load_valid}, 32'd0);
        chk("udf_sp", sp_out, 32'd2047);
`else
        chk("wrap_rd", {31'b0, mem_read}, 32'd1);
        chk("wrap_addr", mem_address, 32'd0);
        tick;
        drive(PUSH, 32'h0, 16'h1111, 32'h0);
        #1;
        chk("wrap_ld", {16'b0, load_data}, 32'h0BEE);
        chk("wrap_sp0", sp_out, 32'd0);
        chk("wrap_push_addr", mem_address, 32'd0);
        tick;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("wrap_mem0", {16'b0, tbmem[0]}, 32'h1111);
        chk("wrap_sp_top", sp_out, 32'd2047);
`endif

        // NOP / op 7 interleaved with LOAD
        drive(OP7, 32'h10, 16'h9999, 32'h0);
        #1;
        chk("op7_cs", {31'b0, mem_cs}, 32'd0);
        tick;
        chk("op7_lv", {31'b0, load_valid}, 32'd0);
        drive(LOAD, 32'h10, 16'h0, 32'h0);
        tick;
        drive(NOP, 32'h0, 16'h0, 32'h0);
        #1;
        chk("mix_lv", {31'b0, load_valid}, 32'd1);
        chk("mix_ld", {16'b0, load_data}, 32'h1234);
        chk("nop_cs", {31'b0, mem_cs}, 32'd0);
        tick;
        drive(OP7, 32'h0, 16'h0, 32'h0);
        #1;
        chk("mix_lv_drop", {31'b0, load_valid}, 32'd0);
        chk("op7b_cs", {31'b0, mem_cs}, 32'd0);
        tick;
        chk("op7b_lv", {31'b0, load_valid}, 32'd0);
        chk("final_sp", sp_out, 32'd2047);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/stack_mem_controller.md
Name: stack_mem_controller

Overview:
- MEM-stage initiator for the 16-bit, 2K-word data memory: decodes the pipeline memory op and drives address, write data, read/write strobes and chip select.
- Owns the stack pointer. Stack grows downward from the top of memory; the data area sits at low addresses.
- Splits 32-bit PC save/restore (CALL/INT/RET/RTI) into two 16-bit accesses and stalls the pipeline for one cycle while doing so.

Parameters:
- ADDR_W, 11, effective word-address width; SP wraps modulo 2^ADDR_W.
- SP_INIT, 2047, SP value after reset (top of stack, empty).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  3  memory op: 0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 PUSH_PC, 6 POP_PC, 7 treated as NOP.
- addr_in  in  32  effective address for LOAD/STORE.
- wdata_in  in  16  data for STORE/PUSH.
- pc_in  in  32  return PC for PUSH_PC.
- mem_read_data  in  16  combinational read data from memory.
- mem_address  out  32  address to memory; upper bits zero-extended from ADDR_W.
- mem_write_data  out  16  write data to memory.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_cs  out  1  chip select; equals mem_read | mem_write.
- stall  out  1  pipeline hold request.
- load_data  out  16  registered LOAD/POP result.
- load_valid  out  1  one-cycle pulse; load_data updated.
- pc_out  out  32  registered restored PC.
- pc_valid  out  1  one-cycle pulse; pc_out updated.
- sp_out  out  32  current SP, zero-extended.

Behaviour:
- Reset (rst=1 at a clock edge):
  - SP=SP_INIT, FSM=IDLE.
  - load_data=0, pc_out=0, load_valid=0, pc_valid=0.
  - All combinational strobes are forced 0 while rst=1.
  - Reset mid PUSH_PC/POP_PC abandons the second access; no further write is issued.
- Strobes are combinational from (op, state, SP). mem_read and mem_write are never both 1.
- FSM states are IDLE and SECOND. op is sampled only in IDLE.
- IDLE, single-cycle ops:
  - LOAD: mem_read=1, mem_address=addr_in. load_data<=mem_read_data at the edge; load_valid=1 next cycle.
  - STORE: mem_write=1, address=addr_in, data=wdata_in.
  - PUSH: write wdata_in to mem[SP]; SP<=SP-1.
  - POP: read mem[SP+1]; SP<=SP+1; load_data captured; load_valid=1 next cycle.
- IDLE, two-cycle ops (stall=1 in this first cycle, FSM->SECOND):
  - PUSH_PC: write pc_in[31:16] to mem[SP]; SP<=SP-1; latch pc_in[15:0].
  - POP_PC: read mem[SP+1] into the low-half latch; SP<=SP+1.
- SECOND (stall=0; op input ignored; FSM->IDLE):
  - PUSH_PC: write the latched low half to mem[SP]; SP<=SP-1.
  - POP_PC: read mem[SP+1] as the high half; SP<=SP+1. pc_out<={high,low}; pc_valid=1 next cycle.
- Net effect: PUSH_PC lowers SP by 2 with the high word at the higher address. POP_PC exactly reverses it.
- Latency:
  - STORE/PUSH: write lands at the edge ending the op cycle.
  - LOAD/POP: result 1 cycle after the op.
  - POP_PC: pc_valid 2 cycles after op first presented.
- Address arithmetic is ADDR_W bits, mod 2^ADDR_W:
  - PUSH at SP=0 writes mem[0] and wraps SP to 2^ADDR_W-1.
  - POP at SP=2^ADDR_W-1 reads mem[0].
- NOP/7: all strobes 0; SP, load_data and pc_out unchanged; valids 0.

Optional Feature:
- Macro STACK_CHECK_EN.
- Defined:
  - Adds output stack_err (1 bit, sticky, cleared only by rst).
  - Sets on PUSH/PUSH_PC word write when SP==0 (overflow), or POP/POP_PC word read when SP==SP_INIT (underflow).
  - The offending access is suppressed: no strobe, SP unchanged, no valid pulse.
  - A two-word op aborted in its first cycle still returns to IDLE after SECOND with no access issued.
- Undefined: no port; silent wrap as above.

Test Plan:
- Reset, then PUSH 0xAAAA, PUSH 0x5555 -> mem[2047]=0xAAAA, mem[2046]=0x5555, sp_out=2045. Then POP, POP -> load_data 0x5555 then 0xAAAA, each with a load_valid pulse; sp_out=2047.
- STORE addr 0x10 data 0x1234, next cycle LOAD 0x10 -> load_valid next cycle with load_data=0x1234; SP unchanged.
- PUSH_PC pc_in=0x0001_ABCD at SP=2047 -> stall high exactly 1 cycle; mem[2047]=0x0001, mem[2046]=0xABCD, SP=2045. POP_PC -> pc_out=0x0001ABCD with one pc_valid pulse; SP=2047.
- Assert rst during the SECOND cycle of PUSH_PC -> no second write (mem[2046] unchanged), SP=2047, stall=0.
- Without STACK_CHECK_EN, POP at SP=2047 -> reads mem[0], SP=0. With STACK_CHECK_EN, same stimulus -> stack_err=1, no mem_read, SP stays 2047.
- Op 7 and NOP interleaved with LOAD -> no strobes during NOP/7; load_valid pulses only after the LOAD.
